vga_timing_ctrl: RTL and testbench

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

---
 rtl/vga_timing_ctrl_pkg.sv | 31 +++
 rtl/vga_timing_ctrl_if.sv | 25 ++
 rtl/vga_timing_ctrl_dot_ce_gen.sv | 28 ++
 rtl/vga_timing_ctrl.sv | 105 ++++++++++
 tb/tb_vga_timing_ctrl.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/vga_timing_ctrl_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing defaults, counter type and FSM encoding
package vga_timing_pkg;

   localparam int CNT_W = 10;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic int total(input int a, input int b, input int c, input int d);
      return a + b + c + d;
   endfunction

   localparam int DEF_DIV_RATIO = 10;
   localparam int DEF_H_ACTIVE  = 640;
   localparam int DEF_H_FP      = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BP      = 48;
   localparam int DEF_V_ACTIVE  = 480;
   localparam int DEF_V_FP      = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BP      = 33;

   localparam int DEF_H_TOTAL = total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int DEF_V_TOTAL = total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// vga_timing_ctrl_if: scan request and video timing outputs of the VGA timing controller
interface vga_timing_ctrl_if;
   import vga_timing_pkg::*;

   logic enable;
   logic dot_en;
   logic hsync;
   logic vsync;
   logic active;
   cnt_t x;
   cnt_t y;
   logic frame_start;
   logic busy;

   modport master (
      input  enable,
      output dot_en, hsync, vsync, active, x, y, frame_start, busy
   );

   modport slave (
      output enable,
      input  dot_en, hsync, vsync, active, x, y, frame_start, busy
   );

endinterface

// File: rtl/vga_timing_ctrl_dot_ce_gen.sv
// dot_ce_gen: divides clk252 into a one-cycle dot strobe while the scan runs
module dot_ce_gen
   import vga_timing_pkg::*;
#(
   parameter int DIV_RATIO = DEF_DIV_RATIO
) (
   input  logic clk252,
   input  logic rst,
   input  logic run,
   output logic dot_en
);

   localparam int W = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
   localparam logic [W-1:0] LAST = W'(DIV_RATIO - 1);

   logic [W-1:0] div;

   // divider parks at 0 when stopped so the first strobe lands DIV_RATIO cycles after start
   always_ff @(posedge clk252) begin
      if (rst || !run)
         div <= '0;
      else
         div <= (div == LAST) ? '0 : div + W'(1);
   end

   assign dot_en = run && (div == LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA scan FSM, dot counters and registered sync/visible decodes
module vga_timing_ctrl
   import vga_timing_pkg::*;
#(
   parameter int DIV_RATIO = DEF_DIV_RATIO,
   parameter int H_ACTIVE  = DEF_H_ACTIVE,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_ACTIVE  = DEF_V_ACTIVE,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP
) (
   input logic               clk252,
   input logic               rst,
   vga_timing_ctrl_if.master vga
);

   localparam cnt_t H_LAST = cnt_t'(total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
   localparam cnt_t V_LAST = cnt_t'(total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
   localparam cnt_t H_VIS  = cnt_t'(H_ACTIVE);
   localparam cnt_t V_VIS  = cnt_t'(V_ACTIVE);
   localparam cnt_t H_SS   = cnt_t'(H_ACTIVE + H_FP);
   localparam cnt_t H_SE   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam cnt_t V_SS   = cnt_t'(V_ACTIVE + V_FP);
   localparam cnt_t V_SE   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

   state_t state;
   state_t state_nx;
   cnt_t   h_cnt;
   cnt_t   v_cnt;
   logic   run;
   logic   dot_en;
   logic   dot_start;
   logic   h_wrap;
   logic   frame_end;
   logic   vis;

   assign run       = (state != IDLE);
   assign h_wrap    = (h_cnt == H_LAST);
   assign frame_end = dot_en && h_wrap && (v_cnt == V_LAST);
   assign vis       = run && (h_cnt < H_VIS) && (v_cnt < V_VIS);

   dot_ce_gen #(
      .DIV_RATIO(DIV_RATIO)
   ) u_dot_ce_gen (
      .clk252,
      .rst,
      .run,
      .dot_en
   );

   // scan state register
   always_ff @(posedge clk252) begin
      state <= rst ? IDLE : state_nx;
   end

   // enable restarts or keeps the scan; without it a running frame drains to its last dot
   always_comb begin
      state_nx = state;
      vga.busy = run;
      state_nx = vga.enable ? RUN :
                 (state == IDLE || (state == DRAIN && frame_end)) ? IDLE : DRAIN;
   end

   // dot and line counters, wrapped explicitly at the programmed totals
   always_ff @(posedge clk252) begin
      if (rst || !run) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (dot_en) begin
         h_cnt <= h_wrap ? '0 : h_cnt + cnt_t'(1);
         if (h_wrap)
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + cnt_t'(1);
      end
   end

   // flags the first clk252 cycle of every dot, including the first dot after leaving IDLE
   always_ff @(posedge clk252) begin
      dot_start <= !rst && (dot_en || (state == IDLE && state_nx == RUN));
   end

   // registered decodes, one cycle behind the counters and steady for the whole dot
   always_ff @(posedge clk252) begin
      if (rst) begin
         vga.hsync       <= 1'b1;
         vga.vsync       <= 1'b1;
         vga.active      <= 1'b0;
         vga.x           <= '0;
         vga.y           <= '0;
         vga.frame_start <= 1'b0;
      end else begin
         vga.hsync       <= !(h_cnt >= H_SS && h_cnt < H_SE);
         vga.vsync       <= !(v_cnt >= V_SS && v_cnt < V_SE);
         vga.active      <= vis;
         vga.x           <= vis ? h_cnt : '0;
         vga.y           <= vis ? v_cnt : '0;
         vga.frame_start <= run && dot_start && h_cnt == '0 && v_cnt == '0;
      end
   end

   assign vga.dot_en = dot_en;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: scoreboard bench for a scaled-down raster (15x10 dots, 3 clocks per dot)
module tb_vga_timing_ctrl;

   localparam int D  = 3;
   localparam int HT = 15;
   localparam int VT = 10;
   localparam int F  = 450;

   typedef struct {
      int          cyc;
      logic [24:0] exp;
   } snap_t;

   localparam logic [24:0] IDLE_V = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0};

   logic  clk252 = 1'b0;
   logic  rst = 1'b1;
   int    cyc = 0;
   int    vectors = 0;
   int    errs = 0;
   snap_t snap_q[$];
   int    fs_q[$];
   snap_t s;

   vga_timing_ctrl_if vif();

   vga_timing_ctrl #(
      .DIV_RATIO(D),
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) dut (
      .clk252(clk252),
      .rst(rst),
      .vga(vif)
   );

   always #5 clk252 = ~clk252;

   always @(posedge clk252) cyc <= cyc + 1;

   function automatic logic [24:0] vec(input logic de, input logic bz, input logic hs, input logic vs,
                                       input logic a, input int x, input int y);
      return {de, bz, hs, vs, a, 10'(x), 10'(y)};
   endfunction

   task automatic chk(input string name, input int c, input logic [24:0] act, input logic [24:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, c, act, exp);
      end
   endtask

   task automatic snap(input int c, input logic [24:0] e);
      snap_q.push_back('{c, e});
   endtask

   task automatic dot(input int base, input int h, input int v, input logic hs, input logic vs,
                      input logic a, input int x, input int y);
      int n = base + (v * HT + h) * D;
      snap(n + 1, vec(1'b0, 1'b1, hs, vs, a, x, y));
      snap(n + D - 1, vec(1'b1, 1'b1, hs, vs, a, x, y));
   endtask

   task automatic frame_tbl(input int b);
      dot(b,  0, 0, 1, 1, 1, 0, 0);
      dot(b,  1, 0, 1, 1, 1, 1, 0);
      dot(b,  7, 0, 1, 1, 1, 7, 0);
      dot(b,  8, 0, 1, 1, 0, 0, 0);
      dot(b,  9, 0, 1, 1, 0, 0, 0);
      dot(b, 10, 0, 0, 1, 0, 0, 0);
      dot(b, 12, 0, 0, 1, 0, 0, 0);
      dot(b, 13, 0, 1, 1, 0, 0, 0);
      dot(b, 14, 0, 1, 1, 0, 0, 0);
      dot(b,  0, 1, 1, 1, 1, 0, 1);
      dot(b,  3, 2, 1, 1, 1, 3, 2);
      dot(b,  7, 5, 1, 1, 1, 7, 5);
      dot(b,  8, 5, 1, 1, 0, 0, 0);
      dot(b,  0, 6, 1, 1, 0, 0, 0);
      dot(b,  0, 7, 1, 0, 0, 0, 0);
      dot(b, 11, 8, 0, 0, 0, 0, 0);
      dot(b,  0, 9, 1, 1, 0, 0, 0);
      dot(b, 14, 9, 1, 1, 0, 0, 0);
   endtask

   task automatic step_to(input int c);
      while (cyc < c) begin
         @(posedge clk252);
         #1;
      end
   endtask

   // monitor: frame_start pulses and scheduled output snapshots against the queues
   always @(negedge clk252) begin
      if (vif.frame_start === 1'b1) begin
         if (fs_q.size() == 0)
            chk("frame_start_extra", cyc, 25'(cyc), 25'(0));
         else
            chk("frame_start", cyc, 25'(cyc), 25'(fs_q.pop_front()));
      end else if (fs_q.size() != 0 && fs_q[0] <= cyc) begin
         chk("frame_start_missing", cyc, 25'(0), 25'(fs_q.pop_front()));
      end
      while (snap_q.size() != 0 && snap_q[0].cyc <= cyc) begin
         s = snap_q.pop_front();
         chk("outputs", s.cyc,
             {vif.dot_en, vif.busy, vif.hsync, vif.vsync, vif.active, vif.x, vif.y}, s.exp);
      end
   end

   initial begin
      int c0;
      vif.enable = 1'b0;
      for (int c = 2; c <= 5; c++) snap(c, IDLE_V);
      step_to(3);
      vif.enable = 1'b1;
      step_to(5);
      rst = 1'b0;
      c0 = cyc + 1;
      fs_q.push_back(c0 + 1);
      fs_q.push_back(c0 + 1 + F);
      fs_q.push_back(c0 + 1 + 2 * F);
      frame_tbl(c0);
      dot(c0 + F, 0, 0, 1, 1, 1, 0, 0);
      dot(c0 + F, 7, 5, 1, 1, 1, 7, 5);
      dot(c0 + 2 * F, 7, 5, 1, 1, 1, 7, 5);
      dot(c0 + 2 * F, 11, 8, 0, 0, 0, 0, 0);
      dot(c0 + 2 * F, 14, 9, 1, 1, 0, 0, 0);
      snap(c0 + 3 * F, IDLE_V);
      snap(c0 + 3 * F + 10, IDLE_V);
      step_to(c0 + 2 * F + 3 * HT * D);
      vif.enable = 1'b0;
      step_to(c0 + 3 * F + 20);

      vif.enable = 1'b1;
      c0 = cyc + 1;
      fs_q.push_back(c0 + 1);
      fs_q.push_back(c0 + 1 + F);
      dot(c0, 0, 0, 1, 1, 1, 0, 0);
      dot(c0, 3, 2, 1, 1, 1, 3, 2);
      dot(c0, 7, 5, 1, 1, 1, 7, 5);
      dot(c0, 12, 6, 0, 1, 0, 0, 0);
      dot(c0, 0, 8, 1, 0, 0, 0, 0);
      dot(c0 + F, 0, 0, 1, 1, 1, 0, 0);
      dot(c0 + F, 3, 2, 1, 1, 1, 3, 2);
      step_to(c0 + 2 * HT * D);
      vif.enable = 1'b0;
      step_to(c0 + 5 * HT * D);
      vif.enable = 1'b1;
      step_to(c0 + F + 50 * D + 1);
      rst = 1'b1;
      snap(cyc + 1, IDLE_V);
      step_to(cyc + 1);
      rst = 1'b0;

      c0 = cyc + 1;
      fs_q.push_back(c0 + 1);
      fs_q.push_back(c0 + 1 + F);
      dot(c0, 0, 0, 1, 1, 1, 0, 0);
      dot(c0, 1, 0, 1, 1, 1, 1, 0);
      dot(c0, 7, 0, 1, 1, 1, 7, 0);
      dot(c0, 8, 0, 1, 1, 0, 0, 0);
      dot(c0 + F, 0, 0, 1, 1, 1, 0, 0);
      step_to(c0 + F + 20);

      chk("frame_start_pending", cyc, 25'(fs_q.size()), 25'(0));
      chk("outputs_pending", cyc, 25'(snap_q.size()), 25'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
